gemm_tile_sequencer: RTL and testbench

Tile-level driver and collector for the fixed-weight GEMM array. It buffers a tile of TILE_ROWS activation rows loaded over a valid/ready port and streams them into the array one row per cycle. It captures each result row exactly LATENCY cycles after issue and returns the results over a valid/ready port. It sits between the system-side load/unload logic and the GEMM `activation_inputs` / `activation_outputs` / `output_valid` pins.

---
 rtl/gemm_tile_sequencer.sv | 154 +++++++++++++++
 tb/tb_gemm_tile_sequencer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gemm_tile_sequencer.sv
// Buffers one activation tile, streams it into the GEMM array one row per cycle,
// and collects each result row a fixed LATENCY cycles after its issue for unload.
module gemm_tile_sequencer #(
  parameter int SA_SIZE                = 4,
  parameter int WEIGHT_ACTIVATION_SIZE = 8,
  parameter int TILE_ROWS              = 8,
  parameter int LATENCY                = 2 * SA_SIZE
) (
  input  logic                                            clk,
  input  logic                                            resetn,
  input  logic                                            load_valid,
  output logic                                            load_ready,
  input  logic [SA_SIZE-1:0][WEIGHT_ACTIVATION_SIZE-1:0]  load_row,
  input  logic                                            start,
  output logic                                            busy,
  output logic                                            done,
  input  logic                                            sa_ready,
  output logic [SA_SIZE-1:0][WEIGHT_ACTIVATION_SIZE-1:0]  sa_act_out,
  input  logic [SA_SIZE-1:0][WEIGHT_ACTIVATION_SIZE-1:0]  sa_act_in,
  output logic                                            res_valid,
  input  logic                                            res_ready,
  output logic [SA_SIZE-1:0][WEIGHT_ACTIVATION_SIZE-1:0]  res_row
);

  localparam int W     = WEIGHT_ACTIVATION_SIZE;
  localparam int CNT_W = $clog2(TILE_ROWS) + 1;
  localparam int CYC_W = $clog2(LATENCY + TILE_ROWS) + 1;
  localparam int IDX_W = (TILE_ROWS > 1) ? $clog2(TILE_ROWS) : 1;

  localparam logic [CNT_W-1:0] ROWS       = CNT_W'(TILE_ROWS);
  localparam logic [CNT_W-1:0] LAST_ROW   = CNT_W'(TILE_ROWS - 1);
  localparam logic [CYC_W-1:0] LAST_ISSUE = CYC_W'(TILE_ROWS - 1);
  localparam logic [CYC_W-1:0] CAP_FIRST  = CYC_W'(LATENCY);
  localparam logic [CYC_W-1:0] CAP_LAST   = CYC_W'(LATENCY + TILE_ROWS - 1);

  typedef logic [SA_SIZE-1:0][W-1:0] row_t;
  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, UNLOAD} state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   load_cnt_q;
  logic [CNT_W-1:0]   rd_idx_q;
  logic [CYC_W-1:0]   cyc_q;
  logic               busy_q;
  logic               done_q;
  logic               res_valid_q;
  row_t               sa_act_out_q;

  row_t               in_buf_q  [TILE_ROWS];
  row_t               out_buf_q [TILE_ROWS];

  logic               load_fire;
  logic               start_ok;
  logic               capturing;
  logic               unload_fire;
  logic [CYC_W-1:0]   cyc_d;
  logic [IDX_W-1:0]   load_idx;
  logic [IDX_W-1:0]   issue_idx;
  logic [IDX_W-1:0]   cap_idx;
  logic [IDX_W-1:0]   rd_idx;

  assign load_ready  = (state_q == IDLE) && (load_cnt_q < ROWS);
  assign load_fire   = load_valid && load_ready;
  assign start_ok    = (state_q == IDLE) && start && (load_cnt_q == ROWS) && sa_ready;
  assign unload_fire = res_valid_q && res_ready;

  // cyc runs continuously from the first issue, so the capture window may open while still streaming
  assign capturing = ((state_q == STREAM) || (state_q == DRAIN)) &&
                     (cyc_q >= CAP_FIRST) && (cyc_q <= CAP_LAST);

  assign cyc_d     = cyc_q + CYC_W'(1);
  assign load_idx  = IDX_W'(load_cnt_q);
  assign issue_idx = IDX_W'(cyc_d);
  assign cap_idx   = IDX_W'(cyc_q - CAP_FIRST);
  assign rd_idx    = IDX_W'(rd_idx_q);

  // Tile storage carries no reset; every entry is written before it is read within a tile.
  always_ff @(posedge clk) begin
    if (load_fire) begin
      in_buf_q[load_idx] <= load_row;
    end
    if (capturing) begin
      out_buf_q[cap_idx] <= sa_act_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= IDLE;
      load_cnt_q   <= '0;
      rd_idx_q     <= '0;
      cyc_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      res_valid_q  <= 1'b0;
      sa_act_out_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (load_fire) begin
            load_cnt_q <= load_cnt_q + CNT_W'(1);
          end
          if (start_ok) begin
            state_q      <= STREAM;
            cyc_q        <= '0;
            busy_q       <= 1'b1;
            sa_act_out_q <= in_buf_q[IDX_W'(0)];
          end
        end
        STREAM: begin
          cyc_q <= cyc_d;
          // sa_act_out is registered, so the row for the next cycle is selected here
          if (cyc_q == LAST_ISSUE) begin
            state_q      <= DRAIN;
            sa_act_out_q <= '0;
          end else begin
            sa_act_out_q <= in_buf_q[issue_idx];
          end
        end
        DRAIN: begin
          cyc_q <= cyc_d;
          if (cyc_q == CAP_LAST) begin
            state_q     <= UNLOAD;
            done_q      <= 1'b1;
            res_valid_q <= 1'b1;
          end
        end
        UNLOAD: begin
          if (unload_fire) begin
            if (rd_idx_q == LAST_ROW) begin
              state_q     <= IDLE;
              rd_idx_q    <= '0;
              load_cnt_q  <= '0;
              res_valid_q <= 1'b0;
              busy_q      <= 1'b0;
            end else begin
              rd_idx_q <= rd_idx_q + CNT_W'(1);
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign res_valid  = res_valid_q;
  assign sa_act_out = sa_act_out_q;
  assign res_row    = res_valid_q ? out_buf_q[rd_idx] : '0;

endmodule

// File: tb/tb_gemm_tile_sequencer.sv
// Two sequencers (LATENCY 8 and 3) each driving a delay-line stand-in for the GEMM
// array, compared every cycle against a timeline model of the tile protocol.
module tb_gemm_tile_sequencer;

  localparam int SA = 4;
  localparam int W  = 8;
  localparam int TR = 8;

  typedef logic [SA-1:0][W-1:0] row_t;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  int cnt = 0;
  always @(posedge clk) cnt <= cnt + 1;

  logic load_valid_s [2];
  logic start_s      [2];
  logic sa_ready_s   [2];
  logic res_ready_s  [2];
  row_t load_row_s   [2];
  logic load_ready_o [2];
  logic busy_o       [2];
  logic done_o       [2];
  logic res_valid_o  [2];
  row_t sa_act_out_o [2];
  row_t res_row_o    [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 2 * SA : 3;
    row_t pipe [LAT];
    row_t act_in;

    always @(posedge clk) begin
      pipe[0] <= sa_act_out_o[g];
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign act_in = pipe[LAT-1];

    gemm_tile_sequencer #(
      .SA_SIZE(SA), .WEIGHT_ACTIVATION_SIZE(W), .TILE_ROWS(TR), .LATENCY(LAT)
    ) dut (
      .clk(clk), .resetn(resetn),
      .load_valid(load_valid_s[g]), .load_ready(load_ready_o[g]), .load_row(load_row_s[g]),
      .start(start_s[g]), .busy(busy_o[g]), .done(done_o[g]), .sa_ready(sa_ready_s[g]),
      .sa_act_out(sa_act_out_o[g]), .sa_act_in(act_in),
      .res_valid(res_valid_o[g]), .res_ready(res_ready_s[g]), .res_row(res_row_o[g])
    );
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(string name, int u, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s dut%0d cycle %0d: got %h expected %h", name, u, cnt, got, exp);
  endtask

  // Timeline model: a tile is described by the cycle its start was taken.
  int   lat_of   [2] = '{8, 3};
  int   m_loaded [2] = '{0, 0};
  int   m_tstart [2] = '{-1, -1};
  int   m_rd     [2] = '{0, 0};
  row_t m_tile   [2][TR];
  bit   live = 1'b0;

  task automatic model_cycle(int u);
    bit   act, e_rv, e_done;
    int   rel;
    row_t e_out, e_res;
    act    = (m_tstart[u] >= 0);
    rel    = cnt - m_tstart[u];
    e_out  = '0;
    if (act && rel >= 1 && rel <= TR) e_out = m_tile[u][rel-1];
    e_rv   = act && (rel >= TR + lat_of[u] + 1);
    e_done = act && (rel == TR + lat_of[u] + 1);
    e_res  = '0;
    if (e_rv) e_res = m_tile[u][m_rd[u]];
    if (live) begin
      chk("load_ready", u, 32'(load_ready_o[u]), 32'(!act && m_loaded[u] < TR));
      chk("busy",       u, 32'(busy_o[u]),       32'(act));
      chk("done",       u, 32'(done_o[u]),       32'(e_done));
      chk("res_valid",  u, 32'(res_valid_o[u]),  32'(e_rv));
      chk("sa_act_out", u, sa_act_out_o[u],      e_out);
      chk("res_row",    u, res_row_o[u],         e_res);
    end
    if (!resetn) begin
      m_loaded[u] = 0; m_tstart[u] = -1; m_rd[u] = 0;
    end else if (!act) begin
      if (load_valid_s[u] && m_loaded[u] < TR) begin
        m_tile[u][m_loaded[u]] = load_row_s[u];
        m_loaded[u]++;
      end else if (start_s[u] && m_loaded[u] == TR && sa_ready_s[u]) begin
        m_tstart[u] = cnt;
      end
    end else if (e_rv && res_ready_s[u]) begin
      m_rd[u]++;
      if (m_rd[u] == TR) begin
        m_rd[u] = 0; m_loaded[u] = 0; m_tstart[u] = -1;
      end
    end
  endtask

  always @(negedge clk) begin
    model_cycle(0);
    model_cycle(1);
    if (!resetn) live = 1'b1;
  end

  row_t issued  [TR];
  row_t results [TR];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_tile(int u, int n, bit pattern, int gapmax);
    for (int i = 0; i < n; i++) begin
      row_t r;
      int   guard;
      if (pattern) for (int j = 0; j < SA; j++) r[j] = W'(16 * i + j);
      else r = $urandom;
      repeat ($urandom_range(gapmax, 0)) step();
      load_valid_s[u] = 1'b1;
      load_row_s[u]   = r;
      guard = 0;
      while (!load_ready_o[u] && guard < 100) begin step(); guard++; end
      chk("load_wait", u, 32'(guard < 100), 32'd1);
      step();
      load_valid_s[u] = 1'b0;
      load_row_s[u]   = $urandom;
    end
  endtask

  task automatic wait_done(int u, int t, output int d);
    d = -1;
    for (int k = 0; k < 200 && d < 0; k++) begin
      if (cnt - t >= 1 && cnt - t <= TR) issued[cnt-t-1] = sa_act_out_o[u];
      if (done_o[u]) d = cnt;
      else step();
    end
    chk("done_seen", u, 32'(d >= 0), 32'd1);
  endtask

  task automatic start_and_wait(int u, bit hold, output int t, output int d);
    start_s[u] = 1'b1;
    t = cnt;
    step();
    if (!hold) start_s[u] = 1'b0;
    wait_done(u, t, d);
  endtask

  // mode 0: ready pattern 1,0,0,1; mode 1: random; otherwise always ready
  task automatic unload(int u, int mode);
    int got = 0, guard = 0, ph = 0;
    while (got < TR && guard < 300) begin
      case (mode)
        0:       res_ready_s[u] = (ph % 4 == 0) || (ph % 4 == 3);
        1:       res_ready_s[u] = 1'($urandom_range(1, 0));
        default: res_ready_s[u] = 1'b1;
      endcase
      if (res_valid_o[u]) begin
        ph++;
        if (res_ready_s[u]) begin results[got] = res_row_o[u]; got++; end
      end
      step();
      guard++;
    end
    res_ready_s[u] = 1'b0;
    chk("unload_count", u, 32'(got), 32'(TR));
  endtask

  initial begin
    int t, d;
    for (int u = 0; u < 2; u++) begin
      load_valid_s[u] = 1'b0; start_s[u] = 1'b0; sa_ready_s[u] = 1'b1;
      res_ready_s[u] = 1'b0;  load_row_s[u] = '0;
    end
    resetn = 1'b0;
    repeat (2) step();
    resetn = 1'b1;
    chk("rst_load_ready", 0, 32'(load_ready_o[0]), 32'd1);
    chk("rst_busy",       1, 32'(busy_o[1]),       32'd0);
    chk("rst_res_valid",  0, 32'(res_valid_o[0]),  32'd0);
    chk("rst_act_out",    1, sa_act_out_o[1],      32'd0);

    // basic tile, patterned rows, LATENCY 8
    load_tile(0, TR, 1'b1, 2);
    start_and_wait(0, 1'b0, t, d);
    chk("done_lat8",  0, 32'(d - t), 32'd17);
    chk("issue_row0", 0, issued[0], 32'h03020100);
    chk("issue_row7", 0, issued[7], 32'h73727170);
    unload(0, 0);
    chk("res_row0", 0, results[0], 32'h03020100);
    chk("res_row5", 0, results[5], 32'h53525150);

    // gated start: 7 rows, then 8 rows with array not ready
    load_tile(0, 7, 1'b0, 1);
    start_s[0] = 1'b1;
    repeat (3) step();
    chk("gate7_busy", 0, 32'(busy_o[0]), 32'd0);
    start_s[0] = 1'b0;
    load_tile(0, 1, 1'b0, 0);
    sa_ready_s[0] = 1'b0;
    start_s[0] = 1'b1;
    repeat (3) step();
    chk("gate_sa_busy", 0, 32'(busy_o[0]), 32'd0);
    chk("gate_sa_out",  0, sa_act_out_o[0], 32'd0);
    start_s[0] = 1'b0;
    load_valid_s[0] = 1'b1;
    load_row_s[0]   = $urandom;
    step();
    chk("ninth_load_ready", 0, 32'(load_ready_o[0]), 32'd0);
    step();
    load_valid_s[0] = 1'b0;
    sa_ready_s[0]   = 1'b1;
    start_and_wait(0, 1'b0, t, d);
    unload(0, 1);

    // overlapping capture, LATENCY 3
    load_tile(1, TR, 1'b1, 0);
    start_and_wait(1, 1'b0, t, d);
    chk("done_lat3", 1, 32'(d - t), 32'd12);
    unload(1, 2);
    chk("lat3_row0", 1, results[0], 32'h03020100);
    chk("lat3_row7", 1, results[7], 32'h73727170);

    // reset during STREAM
    load_tile(0, TR, 1'b0, 1);
    start_s[0] = 1'b1;
    t = cnt;
    step();
    start_s[0] = 1'b0;
    while (cnt < t + 5) step();
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    chk("rstmid_busy",       0, 32'(busy_o[0]),       32'd0);
    chk("rstmid_load_ready", 0, 32'(load_ready_o[0]), 32'd1);
    chk("rstmid_act_out",    0, sa_act_out_o[0],      32'd0);
    repeat (20) step();
    load_tile(0, TR, 1'b0, 0);
    start_and_wait(0, 1'b0, t, d);
    unload(0, 1);

    // back-to-back tiles with start held high
    load_tile(0, TR, 1'b0, 0);
    start_and_wait(0, 1'b1, t, d);
    unload(0, 2);
    chk("b2b_idle_busy",  0, 32'(busy_o[0]),       32'd0);
    chk("b2b_idle_ready", 0, 32'(load_ready_o[0]), 32'd1);
    load_tile(0, TR, 1'b0, 0);
    wait_done(0, -1000, d);
    unload(0, 1);
    start_s[0] = 1'b0;

    // randomized tiles on both instances
    repeat (6) begin
      int u;
      u = int'($urandom_range(1, 0));
      load_tile(u, TR, 1'b0, 3);
      start_and_wait(u, 1'b0, t, d);
      unload(u, 1);
    end

    repeat (3) step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
